// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer
// Serialises two-slot writeback requests (slot A, then slot B) onto the single
// write port of the architectural register file, and keeps a small saturating
// pending-write counter per register so decode can stall on in-flight results.
// A request is accepted on an edge where wb_valid & wb_ready; slot A is written
// in the next cycle and slot B in the cycle after (or the next cycle if slot A
// is disabled). The last write of a request may overlap the accept of the next
// one, so a stream of requests runs with no bubbles.
module regfile_wb_sequencer #(
    parameter int NREG = 16,
    parameter int XLEN = 64,
    parameter int IDXW = 4,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            reset,
    // writeback request from the EX/WB pipeline register
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic            wb_a_en,
    input  logic [IDXW-1:0] wb_a_idx,
    input  logic [XLEN-1:0] wb_a_data,
    input  logic            wb_b_en,
    input  logic [IDXW-1:0] wb_b_idx,
    input  logic [XLEN-1:0] wb_b_data,
    input  logic            wb_sim_end,
    // register-file write port
    output logic            rf_we,
    output logic [IDXW-1:0] rf_widx,
    output logic [XLEN-1:0] rf_wdata,
    // scoreboard interface to decode
    input  logic            sb_set,
    input  logic [IDXW-1:0] sb_set_idx,
    output logic            sb_full,
    input  logic [IDXW-1:0] chk_idx0,
    input  logic [IDXW-1:0] chk_idx1,
    output logic            dep_stall,
    output logic [NREG-1:0] busy_mask,
    output logic            sim_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------
    state_t            state_reg;
    logic              ready_reg;
    logic              done_reg;
    logic              we_reg;
    logic [IDXW-1:0]   widx_reg;
    logic [XLEN-1:0]   wdata_reg;

    // Holding register: slot A goes straight into the write-port registers on
    // accept, so only what is needed after the first write cycle is kept here.
    logic              hold_b_en_reg;
    logic [IDXW-1:0]   hold_b_idx_reg;
    logic [XLEN-1:0]   hold_b_data_reg;
    logic              hold_sim_end_reg;

    // What an accepted request turns into on the accepting edge
    state_t            launch_state;
    logic              launch_we;
    logic [IDXW-1:0]   launch_idx;
    logic [XLEN-1:0]   launch_data;
    logic              launch_ready;
    logic              launch_done;

    logic              accept;
    logic              retiring;

    assign accept   = wb_valid && ready_reg;
    // The current cycle carries the final write of the held request
    assign retiring = (state_reg == WR_B) || ((state_reg == WR_A) && !hold_b_en_reg);

    // Decode the incoming request into the first write-port action
    always_comb begin
        launch_state = IDLE;
        launch_we    = 1'b0;
        launch_idx   = widx_reg;
        launch_data  = wdata_reg;
        launch_ready = !wb_sim_end;
        launch_done  = wb_sim_end;
        if (wb_a_en) begin
            launch_state = WR_A;
            launch_we    = 1'b1;
            launch_idx   = wb_a_idx;
            launch_data  = wb_a_data;
            // A lone slot-A write is also the last write, so the port stays open
            launch_ready = !wb_b_en && !wb_sim_end;
            launch_done  = 1'b0;
        end else if (wb_b_en) begin
            launch_state = WR_B;
            launch_we    = 1'b1;
            launch_idx   = wb_b_idx;
            launch_data  = wb_b_data;
            launch_ready = !wb_sim_end;
            launch_done  = 1'b0;
        end
    end

    // Writeback FSM: latch requests, drive the write port, flag end of simulation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            ready_reg        <= 1'b1;
            done_reg         <= 1'b0;
            we_reg           <= 1'b0;
            widx_reg         <= '0;
            wdata_reg        <= '0;
            hold_b_en_reg    <= 1'b0;
            hold_b_idx_reg   <= '0;
            hold_b_data_reg  <= '0;
            hold_sim_end_reg <= 1'b0;
        end else if ((state_reg == WR_A) && hold_b_en_reg) begin
            // Slot A done, slot B follows; port reopens during the slot-B cycle
            state_reg <= WR_B;
            we_reg    <= 1'b1;
            widx_reg  <= hold_b_idx_reg;
            wdata_reg <= hold_b_data_reg;
            ready_reg <= !hold_sim_end_reg;
        end else if (retiring && hold_sim_end_reg) begin
            // Final instruction fully written: stop accepting for good
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            ready_reg <= 1'b0;
            done_reg  <= 1'b1;
        end else if (accept) begin
            state_reg        <= launch_state;
            we_reg           <= launch_we;
            widx_reg         <= launch_idx;
            wdata_reg        <= launch_data;
            ready_reg        <= launch_ready;
            hold_b_en_reg    <= wb_a_en && wb_b_en;
            hold_b_idx_reg   <= wb_b_idx;
            hold_b_data_reg  <= wb_b_data;
            hold_sim_end_reg <= wb_sim_end;
            if (launch_done) begin
                done_reg <= 1'b1;
            end
        end else begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            ready_reg <= !done_reg;
        end
    end

    assign wb_ready = ready_reg;
    assign rf_we    = we_reg;
    assign rf_widx  = widx_reg;
    assign rf_wdata = wdata_reg;
    assign sim_done = done_reg;

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    logic [CNTW-1:0] cnt_view [NREG];

    // A write retiring on the same register this cycle frees one slot, so a
    // saturated counter can still take a new mark in that cycle.
    assign sb_full = (cnt_view[sb_set_idx] == CNT_MAX) &&
                     !(we_reg && (widx_reg == sb_set_idx));

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
            logic [CNTW-1:0] cnt_reg;
            logic            inc;
            logic            dec;

            assign inc = sb_set && (sb_set_idx == IDXW'(gi)) && !sb_full;
            // A retire against an empty counter is dropped unless it pairs
            // with a same-cycle mark, in which case the two cancel.
            assign dec = we_reg && (widx_reg == IDXW'(gi)) && ((cnt_reg != '0) || inc);

            // Saturating up/down count of outstanding writes to register gi
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (inc && !dec) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end else if (dec && !inc) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end

            assign cnt_view[gi]  = cnt_reg;
            assign busy_mask[gi] = |cnt_reg;
        end
    endgenerate

    // Stall decode while either source register still has a write in flight
    assign dep_stall = busy_mask[chk_idx0] | busy_mask[chk_idx1];

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed testbench for regfile_wb_sequencer: one task per scenario, each
// with its own hand-computed expectations.
module tb_regfile_wb_sequencer;

    localparam int NREG = 16;
    localparam int XLEN = 64;
    localparam int IDXW = 4;
    localparam int CNTW = 2;

    logic            clk;
    logic            reset;
    logic            wb_valid;
    logic            wb_ready;
    logic            wb_a_en;
    logic [IDXW-1:0] wb_a_idx;
    logic [XLEN-1:0] wb_a_data;
    logic            wb_b_en;
    logic [IDXW-1:0] wb_b_idx;
    logic [XLEN-1:0] wb_b_data;
    logic            wb_sim_end;
    logic            rf_we;
    logic [IDXW-1:0] rf_widx;
    logic [XLEN-1:0] rf_wdata;
    logic            sb_set;
    logic [IDXW-1:0] sb_set_idx;
    logic            sb_full;
    logic [IDXW-1:0] chk_idx0;
    logic [IDXW-1:0] chk_idx1;
    logic            dep_stall;
    logic [NREG-1:0] busy_mask;
    logic            sim_done;

    int checks = 0;
    int passed = 0;

    regfile_wb_sequencer #(
        .NREG(NREG), .XLEN(XLEN), .IDXW(IDXW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_a_en(wb_a_en), .wb_a_idx(wb_a_idx), .wb_a_data(wb_a_data),
        .wb_b_en(wb_b_en), .wb_b_idx(wb_b_idx), .wb_b_data(wb_b_data),
        .wb_sim_end(wb_sim_end),
        .rf_we(rf_we), .rf_widx(rf_widx), .rf_wdata(rf_wdata),
        .sb_set(sb_set), .sb_set_idx(sb_set_idx), .sb_full(sb_full),
        .chk_idx0(chk_idx0), .chk_idx1(chk_idx1), .dep_stall(dep_stall),
        .busy_mask(busy_mask), .sim_done(sim_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every register-file write must retire a previously marked pending write
    always @(negedge clk) begin
        if (!reset && rf_we) begin
            checks++;
            if (busy_mask[rf_widx] !== 1'b1)
                $display("FAIL sb_underflow: write to r%0d with busy=%0b, want 1", rf_widx, busy_mask[rf_widx]);
            else passed++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_a_en = 1'b0; wb_a_idx = '0; wb_a_data = '0;
        wb_b_en = 1'b0; wb_b_idx = '0; wb_b_data = '0; wb_sim_end = 1'b0;
        sb_set = 1'b0; sb_set_idx = '0; chk_idx0 = '0; chk_idx1 = '0;
    endtask

    task automatic sb_mark(input logic [IDXW-1:0] idx);
        sb_set = 1'b1; sb_set_idx = idx;
        tick();
        sb_set = 1'b0;
        $display("sb_set r%0d", idx);
    endtask

    task automatic drive_req(input logic a_en, input logic [IDXW-1:0] a_idx, input logic [XLEN-1:0] a_data,
                             input logic b_en, input logic [IDXW-1:0] b_idx, input logic [XLEN-1:0] b_data,
                             input logic sim_end);
        wb_valid = 1'b1; wb_a_en = a_en; wb_a_idx = a_idx; wb_a_data = a_data;
        wb_b_en = b_en; wb_b_idx = b_idx; wb_b_data = b_data; wb_sim_end = sim_end;
        $display("req a_en=%0b r%0d=0x%0h b_en=%0b r%0d=0x%0h end=%0b", a_en, a_idx, a_data, b_en, b_idx, b_data, sim_end);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++; if (wb_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", wb_ready); else passed++;
        checks++; if (rf_we !== 1'b0) $display("FAIL rst_we: got %0b want 0", rf_we); else passed++;
        checks++; if (busy_mask !== 16'h0000) $display("FAIL rst_busy: got %h want 0000", busy_mask); else passed++;
        checks++; if (sim_done !== 1'b0) $display("FAIL rst_done: got %0b want 0", sim_done); else passed++;
        reset = 1'b0;
        tick();
        checks++; if (wb_ready !== 1'b1) $display("FAIL rel_ready: got %0b want 1", wb_ready); else passed++;
        checks++; if (rf_we !== 1'b0) $display("FAIL rel_we: got %0b want 0", rf_we); else passed++;
        checks++; if (dep_stall !== 1'b0) $display("FAIL rel_stall: got %0b want 0", dep_stall); else passed++;
        $display("reset released");
    endtask

    task automatic test_two_write();
        sb_mark(4'd0); sb_mark(4'd2);
        checks++; if (busy_mask !== 16'h0005) $display("FAIL tw_busy0: got %h want 0005", busy_mask); else passed++;
        drive_req(1'b1, 4'd0, 64'h11, 1'b1, 4'd2, 64'h22, 1'b0);
        tick();
        wb_valid = 1'b0;
        checks++; if (rf_we !== 1'b1) $display("FAIL tw_we_a: got %0b want 1", rf_we); else passed++;
        checks++; if (rf_widx !== 4'd0) $display("FAIL tw_idx_a: got %0d want 0", rf_widx); else passed++;
        checks++; if (rf_wdata !== 64'h11) $display("FAIL tw_data_a: got %h want 11", rf_wdata); else passed++;
        checks++; if (wb_ready !== 1'b0) $display("FAIL tw_ready_a: got %0b want 0", wb_ready); else passed++;
        tick();
        checks++; if (rf_we !== 1'b1) $display("FAIL tw_we_b: got %0b want 1", rf_we); else passed++;
        checks++; if (rf_widx !== 4'd2) $display("FAIL tw_idx_b: got %0d want 2", rf_widx); else passed++;
        checks++; if (rf_wdata !== 64'h22) $display("FAIL tw_data_b: got %h want 22", rf_wdata); else passed++;
        checks++; if (wb_ready !== 1'b1) $display("FAIL tw_ready_b: got %0b want 1", wb_ready); else passed++;
        checks++; if (busy_mask !== 16'h0004) $display("FAIL tw_busy1: got %h want 0004", busy_mask); else passed++;
        tick();
        checks++; if (rf_we !== 1'b0) $display("FAIL tw_we_idle: got %0b want 0", rf_we); else passed++;
        checks++; if (busy_mask !== 16'h0000) $display("FAIL tw_busy2: got %h want 0000", busy_mask); else passed++;
    endtask

    task automatic test_back_to_back();
        sb_mark(4'd1); sb_mark(4'd3); sb_mark(4'd5);
        drive_req(1'b1, 4'd1, 64'h101, 1'b0, 4'd0, 64'h0, 1'b0);
        tick();
        checks++; if (rf_we !== 1'b1 || rf_widx !== 4'd1 || rf_wdata !== 64'h101) $display("FAIL bb_w1: got we=%0b r%0d=%h want 1 r1=101", rf_we, rf_widx, rf_wdata); else passed++;
        checks++; if (wb_ready !== 1'b1) $display("FAIL bb_ready1: got %0b want 1", wb_ready); else passed++;
        drive_req(1'b1, 4'd3, 64'h303, 1'b0, 4'd0, 64'h0, 1'b0);
        tick();
        checks++; if (rf_we !== 1'b1 || rf_widx !== 4'd3 || rf_wdata !== 64'h303) $display("FAIL bb_w3: got we=%0b r%0d=%h want 1 r3=303", rf_we, rf_widx, rf_wdata); else passed++;
        drive_req(1'b1, 4'd5, 64'h505, 1'b0, 4'd0, 64'h0, 1'b0);
        tick();
        wb_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_widx !== 4'd5 || rf_wdata !== 64'h505) $display("FAIL bb_w5: got we=%0b r%0d=%h want 1 r5=505", rf_we, rf_widx, rf_wdata); else passed++;
        tick();
        checks++; if (rf_we !== 1'b0) $display("FAIL bb_we_idle: got %0b want 0", rf_we); else passed++;
        checks++; if (busy_mask !== 16'h0000) $display("FAIL bb_busy: got %h want 0000", busy_mask); else passed++;
    endtask

    task automatic test_empty();
        drive_req(1'b0, 4'd6, 64'h6, 1'b0, 4'd6, 64'h6, 1'b0);
        tick();
        wb_valid = 1'b0;
        checks++; if (rf_we !== 1'b0) $display("FAIL em_we: got %0b want 0", rf_we); else passed++;
        checks++; if (wb_ready !== 1'b1) $display("FAIL em_ready: got %0b want 1", wb_ready); else passed++;
    endtask

    task automatic test_same_index();
        sb_mark(4'd4); sb_mark(4'd4);
        checks++; if (busy_mask !== 16'h0010) $display("FAIL si_busy0: got %h want 0010", busy_mask); else passed++;
        drive_req(1'b1, 4'd4, 64'h1000, 1'b1, 4'd4, 64'h5, 1'b0);
        tick();
        wb_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_widx !== 4'd4 || rf_wdata !== 64'h1000) $display("FAIL si_wa: got we=%0b r%0d=%h want 1 r4=1000", rf_we, rf_widx, rf_wdata); else passed++;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_widx !== 4'd4 || rf_wdata !== 64'h5) $display("FAIL si_wb: got we=%0b r%0d=%h want 1 r4=5", rf_we, rf_widx, rf_wdata); else passed++;
        tick();
        checks++; if (rf_we !== 1'b0) $display("FAIL si_we_idle: got %0b want 0", rf_we); else passed++;
        checks++; if (busy_mask !== 16'h0000) $display("FAIL si_busy1: got %h want 0000", busy_mask); else passed++;
    endtask

    task automatic test_scoreboard();
        sb_mark(4'd7); sb_mark(4'd7); sb_mark(4'd7);
        checks++; if (busy_mask !== 16'h0080) $display("FAIL sb_busy3: got %h want 0080", busy_mask); else passed++;
        sb_set = 1'b1; sb_set_idx = 4'd7;
        #1;
        checks++; if (sb_full !== 1'b1) $display("FAIL sb_full4: got %0b want 1", sb_full); else passed++;
        tick();
        sb_set = 1'b0; sb_set_idx = 4'd6;
        #1;
        checks++; if (sb_full !== 1'b0) $display("FAIL sb_full_r6: got %0b want 0", sb_full); else passed++;
        chk_idx0 = 4'd7; chk_idx1 = 4'd0;
        #1;
        checks++; if (dep_stall !== 1'b1) $display("FAIL sb_stall3: got %0b want 1", dep_stall); else passed++;
        // retire on r7 while decode marks r7 again
        drive_req(1'b1, 4'd7, 64'h77, 1'b0, 4'd0, 64'h0, 1'b0);
        tick();
        wb_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_widx !== 4'd7) $display("FAIL sb_wr7: got we=%0b r%0d want 1 r7", rf_we, rf_widx); else passed++;
        sb_set = 1'b1; sb_set_idx = 4'd7;
        #1;
        checks++; if (sb_full !== 1'b0) $display("FAIL sb_full_ret: got %0b want 0", sb_full); else passed++;
        tick();
        sb_set = 1'b0;
        // counter should still be 3: exactly three more retires clear it
        drive_req(1'b1, 4'd7, 64'hA1, 1'b1, 4'd7, 64'hA2, 1'b0);
        tick();
        wb_valid = 1'b0;
        checks++; if (dep_stall !== 1'b1) $display("FAIL sb_stall_c1: got %0b want 1", dep_stall); else passed++;
        tick();
        checks++; if (dep_stall !== 1'b1) $display("FAIL sb_stall_c2: got %0b want 1", dep_stall); else passed++;
        drive_req(1'b1, 4'd7, 64'hA3, 1'b0, 4'd0, 64'h0, 1'b0);
        tick();
        wb_valid = 1'b0;
        chk_idx0 = 4'd0; chk_idx1 = 4'd7;
        #1;
        checks++; if (dep_stall !== 1'b1) $display("FAIL sb_stall_c3: got %0b want 1", dep_stall); else passed++;
        checks++; if (rf_wdata !== 64'hA3) $display("FAIL sb_data_c3: got %h want a3", rf_wdata); else passed++;
        tick();
        checks++; if (dep_stall !== 1'b0) $display("FAIL sb_stall_c4: got %0b want 0", dep_stall); else passed++;
        checks++; if (busy_mask !== 16'h0000) $display("FAIL sb_busy0: got %h want 0000", busy_mask); else passed++;
        chk_idx1 = 4'd0;
    endtask

    task automatic test_sim_end_and_reset();
        sb_mark(4'd8); sb_mark(4'd9);
        drive_req(1'b1, 4'd8, 64'h88, 1'b1, 4'd9, 64'h99, 1'b1);
        tick();
        wb_valid = 1'b0; wb_sim_end = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_widx !== 4'd8 || sim_done !== 1'b0) $display("FAIL se_c1: got we=%0b r%0d done=%0b want 1 r8 0", rf_we, rf_widx, sim_done); else passed++;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_widx !== 4'd9 || sim_done !== 1'b0) $display("FAIL se_c2: got we=%0b r%0d done=%0b want 1 r9 0", rf_we, rf_widx, sim_done); else passed++;
        checks++; if (wb_ready !== 1'b0) $display("FAIL se_ready_c2: got %0b want 0", wb_ready); else passed++;
        tick();
        checks++; if (sim_done !== 1'b1 || rf_we !== 1'b0) $display("FAIL se_c3: got done=%0b we=%0b want 1 0", sim_done, rf_we); else passed++;
        drive_req(1'b1, 4'd8, 64'hDEAD, 1'b0, 4'd0, 64'h0, 1'b0);
        tick(); tick();
        checks++; if (sim_done !== 1'b1 || wb_ready !== 1'b0 || rf_we !== 1'b0) $display("FAIL se_sticky: got done=%0b ready=%0b we=%0b want 1 0 0", sim_done, wb_ready, rf_we); else passed++;
        wb_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        checks++; if (sim_done !== 1'b0 || wb_ready !== 1'b1) $display("FAIL rr_clear: got done=%0b ready=%0b want 0 1", sim_done, wb_ready); else passed++;
        sb_mark(4'd10); sb_mark(4'd11);
        drive_req(1'b1, 4'd10, 64'hAA, 1'b1, 4'd11, 64'hBB, 1'b0);
        tick();
        wb_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_widx !== 4'd10) $display("FAIL rr_wra: got we=%0b r%0d want 1 r10", rf_we, rf_widx); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0 || busy_mask !== 16'h0000 || wb_ready !== 1'b1) $display("FAIL rr_async: got we=%0b busy=%h ready=%0b want 0 0000 1", rf_we, busy_mask, wb_ready); else passed++;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (rf_we !== 1'b0) $display("FAIL rr_we1: got %0b want 0", rf_we); else passed++;
        tick();
        checks++; if (rf_we !== 1'b0 || sim_done !== 1'b0) $display("FAIL rr_we2: got we=%0b done=%0b want 0 0", rf_we, sim_done); else passed++;
    endtask

    initial begin
        test_reset();
        test_two_write();
        test_back_to_back();
        test_empty();
        test_same_index();
        test_scoreboard();
        test_sim_end_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
